// File: rtl/mips_defs.sv
// Shared definitions for the MIPS instruction-fetch stage.
package mips_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Fetch state encoding
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Contents of the IF/ID pipeline register
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// PC register with redirect capture during stalls.
//
//   state | meaning
//   RUN   | normal sequential fetch, no redirect pending
//   HOLD  | a redirect arrived while stalled; pend_pc holds the newest target
module pc_reg
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [31:0] pend_pc;
  logic [31:0] pend_next;
  logic [31:0] pc_next;

  // Next-PC selection; a stall always wins so the delay slot stays at im_addr
  always_comb begin
    pc_next    = pc + 32'd4;
    pend_next  = pend_pc;
    state_next = state;
    if (stall) begin
      pc_next = pc;
      if (redirect) begin
        pend_next  = redirect_pc;
        state_next = ST_HOLD;
      end
    end else if (redirect) begin
      pc_next    = redirect_pc;
      state_next = ST_RUN;
    end else if (state == ST_HOLD) begin
      pc_next    = pend_pc;
      state_next = ST_RUN;
    end
  end

  // State, PC and pending-target registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      pend_pc <= 32'h0000_0000;
      state   <= ST_RUN;
    end else begin
      pc      <= pc_next;
      pend_pc <= pend_next;
      state   <= state_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, fetch counter, alignment flag.
// No flush path exists: the delay-slot instruction always reaches ID.
module fetch_unit
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] fetch_cnt,
  output logic        align_err
);

  logic [31:0] pc;
  ifid_t       ifid;

  pc_reg u_pc (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  assign im_addr  = pc;
  assign id_instr = ifid.instr;
  assign id_pc    = ifid.pc;
  assign id_pc4   = ifid.pc4;

  // IF/ID register and fetch counter advance together on every unstalled edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid      <= '{instr: NOP_WORD, pc: 32'h0, pc4: 32'h0};
      fetch_cnt <= 32'h0;
    end else if (!stall) begin
      ifid      <= '{instr: im_rdata, pc: pc, pc4: pc + 32'd4};
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  // Sticky flag: every redirect is accepted, either into pc or into pend_pc
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      align_err <= 1'b0;
    else if (redirect && misaligned(redirect_pc))
      align_err <= 1'b1;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an expectation queue.
module tb_fetch_unit;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] fetch_cnt;
  logic        align_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        aerr;
  } exp_t;

  exp_t sb[$];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .fetch_cnt   (fetch_cnt),
    .align_err   (align_err)
  );

  always #5 clk = ~clk;

  // Instruction memory: a word derived from its address so each slot is distinct
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign im_rdata = mem(im_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then compare
  task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rpc,
                      input logic [31:0] e_addr, input logic [31:0] e_pc,
                      input logic [31:0] e_cnt, input logic e_aerr);
    exp_t e;
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    e = '{tag: tag, addr: e_addr, pc: e_pc, pc4: e_pc + 32'd4, instr: mem(e_pc),
          cnt: e_cnt, aerr: e_aerr};
    sb.push_back(e);
    tick();
    stall = 1'b0;
    redirect = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".im_addr"},   im_addr,   e.addr);
      chk({e.tag, ".id_pc"},     id_pc,     e.pc);
      chk({e.tag, ".id_pc4"},    id_pc4,    e.pc4);
      chk({e.tag, ".id_instr"},  id_instr,  e.instr);
      chk({e.tag, ".fetch_cnt"}, fetch_cnt, e.cnt);
      chk({e.tag, ".align_err"}, {31'h0, align_err}, {31'h0, e.aerr});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".im_addr"},   im_addr,   32'h0000_3000);
    chk({tag, ".id_instr"},  id_instr,  32'h0);
    chk({tag, ".id_pc"},     id_pc,     32'h0);
    chk({tag, ".id_pc4"},    id_pc4,    32'h0);
    chk({tag, ".fetch_cnt"}, fetch_cnt, 32'h0);
    chk({tag, ".align_err"}, {31'h0, align_err}, 32'h0);
    chk({tag, ".state"},     {31'h0, dut.u_pc.state}, 32'h0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 chk_reset("rst_async");
    tick();
    tick();
    chk_reset("rst_hold");
    reset = 1'b0;

    // Sequential fetch
    step("seq0", 0, 0, 32'h0, 32'h0000_3004, 32'h0000_3000, 32'd1, 1'b0);
    step("seq1", 0, 0, 32'h0, 32'h0000_3008, 32'h0000_3004, 32'd2, 1'b0);
    step("seq2", 0, 0, 32'h0, 32'h0000_300C, 32'h0000_3008, 32'd3, 1'b0);
    // Taken branch: delay slot 300C enters ID, then target 3040
    step("br_ds",  0, 1, 32'h0000_3040, 32'h0000_3040, 32'h0000_300C, 32'd4, 1'b0);
    step("br_tgt", 0, 0, 32'h0,         32'h0000_3044, 32'h0000_3040, 32'd5, 1'b0);
    // Redirect captured under stall
    step("stl0", 1, 1, 32'h0000_3100, 32'h0000_3044, 32'h0000_3040, 32'd5, 1'b0);
    chk("stl0.state", {31'h0, dut.u_pc.state}, 32'h1);
    step("stl1", 1, 0, 32'h0, 32'h0000_3044, 32'h0000_3040, 32'd5, 1'b0);
    step("stl2", 1, 0, 32'h0, 32'h0000_3044, 32'h0000_3040, 32'd5, 1'b0);
    chk("stl2.state", {31'h0, dut.u_pc.state}, 32'h1);
    step("rel",   0, 0, 32'h0, 32'h0000_3100, 32'h0000_3044, 32'd6, 1'b0);
    step("rel1",  0, 0, 32'h0, 32'h0000_3104, 32'h0000_3100, 32'd7, 1'b0);
    // Pending 3100 superseded by redirect on release
    step("ovr_h", 1, 1, 32'h0000_3100, 32'h0000_3104, 32'h0000_3100, 32'd7, 1'b0);
    step("ovr_r", 0, 1, 32'h0000_3200, 32'h0000_3200, 32'h0000_3104, 32'd8, 1'b0);
    step("ovr_n", 0, 0, 32'h0, 32'h0000_3204, 32'h0000_3200, 32'd9, 1'b0);
    // Newest target wins among redirects under one stall
    step("hh0", 1, 1, 32'h0000_3300, 32'h0000_3204, 32'h0000_3200, 32'd9, 1'b0);
    step("hh1", 1, 1, 32'h0000_3400, 32'h0000_3204, 32'h0000_3200, 32'd9, 1'b0);
    step("hh2", 0, 0, 32'h0, 32'h0000_3400, 32'h0000_3204, 32'd10, 1'b0);
    // Misaligned target: loaded unmodified, flag sticky
    step("mis0", 0, 1, 32'h0000_3202, 32'h0000_3202, 32'h0000_3400, 32'd11, 1'b1);
    step("mis1", 0, 0, 32'h0, 32'h0000_3206, 32'h0000_3202, 32'd12, 1'b1);
    // Wrap-around
    step("wrap0", 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3206, 32'd13, 1'b1);
    step("wrap1", 0, 0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 32'd14, 1'b1);
    step("wrap2", 0, 0, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'd15, 1'b1);
    // Async reset while HOLD
    step("hold", 1, 1, 32'h0000_3500, 32'h0000_0004, 32'h0000_0000, 32'd15, 1'b1);
    chk("hold.state", {31'h0, dut.u_pc.state}, 32'h1);
    stall = 1'b1;
    #3 reset = 1'b1;
    #1 chk_reset("rst_mid");
    tick();
    tick();
    reset = 1'b0;
    stall = 1'b0;
    step("post0", 0, 0, 32'h0, 32'h0000_3004, 32'h0000_3000, 32'd1, 1'b0);
    step("post1", 0, 0, 32'h0, 32'h0000_3008, 32'h0000_3004, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
